// File: rtl/fp_pkg.sv
// Shared floating-point helpers: bias and special-value patterns for any exponent/mantissa
// width, operand classes, and bit positions inside the 4-bit exception flags word.
package fp_pkg;

    typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_e;

    localparam int FLAGS_W      = 4;
    localparam int FLAG_INVALID = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Positive infinity: exponent all ones, mantissa zero.
    function automatic logic [63:0] fp_inf(input int exp_w, input int man_w);
        return ((64'd1 << exp_w) - 64'd1) << man_w;
    endfunction

    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        return fp_inf(exp_w, man_w) | (64'd1 << (man_w - 1));
    endfunction

endpackage

// File: rtl/fpmul_pipe_if.sv
// Operand/result handshake bundle of fpmul_pipe; the flags member exists only with FPMUL_FLAGS_EN.
interface fpmul_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x1;
    logic [W-1:0] x2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
`ifdef FPMUL_FLAGS_EN
    logic [3:0]   flags;
`endif

    modport master (
        output in_valid, x1, x2, out_ready,
        input  in_ready, out_valid, y
`ifdef FPMUL_FLAGS_EN
        , input flags
`endif
    );

    modport slave (
        input  in_valid, x1, x2, out_ready,
        output in_ready, out_valid, y
`ifdef FPMUL_FLAGS_EN
        , output flags
`endif
    );

endinterface

// File: rtl/fpmul_round.sv
// Combinational normalise + round-to-nearest-even of a (MAN_W+1)x(MAN_W+1) mantissa product.
// Exponent comes back adjusted for the normalise shift and any rounding carry-out.
module fpmul_round #(
    parameter int MAN_W = 7,
    parameter int EW    = 10
) (
    input  logic [2*MAN_W+1:0]   prod_i,
    input  logic signed [EW-1:0] exp_i,
    output logic [MAN_W-1:0]     man_o,
    output logic signed [EW-1:0] exp_o
`ifdef FPMUL_FLAGS_EN
    ,
    output logic                 inexact_o
`endif
);
    localparam int PW = 2 * MAN_W + 2;

    logic                 msb;
    logic [PW-2:0]        norm;
    logic                 g, r, s, rnd_up;
    logic [MAN_W:0]       man_inc;
    logic signed [EW-1:0] exp_inc;

    always_comb begin
        msb  = prod_i[PW-1];
        // Leading one of the normalised product sits just above bit PW-2 and is dropped.
        norm = msb ? prod_i[PW-2:0] : {prod_i[PW-3:0], 1'b0};
        g    = norm[PW-2-MAN_W];
        r    = norm[PW-3-MAN_W];
        s    = |norm[PW-4-MAN_W:0];
        rnd_up  = g & (r | s | norm[PW-1-MAN_W]);
        man_inc = {1'b0, norm[PW-2 -: MAN_W]} + {{MAN_W{1'b0}}, rnd_up};
        exp_inc = EW'(msb) + EW'(man_inc[MAN_W]);
        exp_o   = exp_i + exp_inc;
        man_o   = man_inc[MAN_W-1:0];
    end

`ifdef FPMUL_FLAGS_EN
    assign inexact_o = g | r | s;
`endif
endmodule

// File: rtl/myreg.sv
// Generic enabled register with synchronous active-high clear.
module myreg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    always_ff @(posedge clk) begin
        if (rst) begin
            q_o <= '0;
        end else if (en) begin
            q_o <= d_i;
        end
    end
endmodule

// File: rtl/fpmul_pipe.sv
// 3-stage pipelined FP multiplier (RNE, subnormals flushed); all stages shift together on advance.
// Define FPMUL_FLAGS_EN to add the registered {invalid, overflow, underflow, inexact} flags.
module fpmul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7
) (
    input logic         clk,
    input logic         rst,
    fpmul_pipe_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam int EW = EXP_W + 2;
    localparam logic [W-1:0]         INF  = W'(fp_inf(EXP_W, MAN_W));
    localparam logic [W-1:0]         QNAN = W'(fp_qnan(EXP_W, MAN_W));
    localparam logic signed [EW-1:0] BIAS = EW'(fp_bias(EXP_W));
    localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

    typedef struct packed {
        logic                 sgn;
        fp_class_e            ca;
        fp_class_e            cb;
        logic [PW-1:0]        prod;
        logic signed [EW-1:0] esum;
    } s2_t;

    typedef enum logic [2:0] {SEL_NAN, SEL_INF, SEL_ZERO, SEL_OVF, SEL_UNF, SEL_NORM} res_sel_e;

    function automatic fp_class_e classify(input logic [W-1:0] x);
        if (x[W-2 -: EXP_W] == '0) return FP_ZERO;
        if (x[W-2 -: EXP_W] != '1) return FP_NORM;
        return (x[MAN_W-1:0] == '0) ? FP_INF : FP_NAN;
    endfunction

    logic                 advance;
    logic                 s1_vld_q, s2_vld_q;
    logic [2*W-1:0]       ops_q;
    logic [W-1:0]         a_q, b_q;
    s2_t                  s2_d, s2_q;
    logic [MAN_W-1:0]     r_man;
    logic signed [EW-1:0] r_exp;
    logic                 inf_zero;
    res_sel_e             sel;
    logic [W-1:0]         y_d;

    assign advance      = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = advance;
    assign a_q          = ops_q[2*W-1:W];
    assign b_q          = ops_q[W-1:0];

    myreg #(.W(1))   u_s1_vld (.clk(clk), .rst(rst), .en(advance), .d_i(bus.in_valid), .q_o(s1_vld_q));
    myreg #(.W(2*W)) u_s1_ops (.clk(clk), .rst(rst), .en(advance), .d_i({bus.x1, bus.x2}), .q_o(ops_q));

    always_comb begin
        s2_d.sgn  = a_q[W-1] ^ b_q[W-1];
        s2_d.ca   = classify(a_q);
        s2_d.cb   = classify(b_q);
        s2_d.prod = PW'({1'b1, a_q[MAN_W-1:0]}) * PW'({1'b1, b_q[MAN_W-1:0]});
        s2_d.esum = EW'(a_q[W-2 -: EXP_W]) + EW'(b_q[W-2 -: EXP_W]) - BIAS;
    end

    myreg #(.W(1))          u_s2_vld (.clk(clk), .rst(rst), .en(advance), .d_i(s1_vld_q), .q_o(s2_vld_q));
    myreg #(.W($bits(s2_t))) u_s2     (.clk(clk), .rst(rst), .en(advance), .d_i(s2_d), .q_o(s2_q));

`ifdef FPMUL_FLAGS_EN
    logic             r_inexact;
    logic [FLAGS_W-1:0] fl_d;
`endif

    fpmul_round #(.MAN_W(MAN_W), .EW(EW)) u_round (
        .prod_i   (s2_q.prod),
        .exp_i    (s2_q.esum),
        .man_o    (r_man),
        .exp_o    (r_exp)
`ifdef FPMUL_FLAGS_EN
        ,
        .inexact_o(r_inexact)
`endif
    );

    always_comb begin
        inf_zero = (s2_q.ca == FP_INF && s2_q.cb == FP_ZERO) || (s2_q.ca == FP_ZERO && s2_q.cb == FP_INF);
        if (s2_q.ca == FP_NAN || s2_q.cb == FP_NAN || inf_zero) sel = SEL_NAN;
        else if (s2_q.ca == FP_INF || s2_q.cb == FP_INF)        sel = SEL_INF;
        else if (s2_q.ca == FP_ZERO || s2_q.cb == FP_ZERO)      sel = SEL_ZERO;
        else if (r_exp >= EMAX)                                 sel = SEL_OVF;
        else if (r_exp[EW-1] || r_exp == '0)                    sel = SEL_UNF;
        else                                                    sel = SEL_NORM;

        y_d = '0;
        if (s2_vld_q) begin
            case (sel)
                SEL_NAN:           y_d = QNAN;
                SEL_INF, SEL_OVF:  y_d = {s2_q.sgn, INF[W-2:0]};
                SEL_ZERO, SEL_UNF: y_d = {s2_q.sgn, {(W-1){1'b0}}};
                default:           y_d = {s2_q.sgn, r_exp[EXP_W-1:0], r_man};
            endcase
        end
    end

    myreg #(.W(1)) u_out_vld (.clk(clk), .rst(rst), .en(advance), .d_i(s2_vld_q), .q_o(bus.out_valid));
    myreg #(.W(W)) u_out_y   (.clk(clk), .rst(rst), .en(advance), .d_i(y_d), .q_o(bus.y));

`ifdef FPMUL_FLAGS_EN
    always_comb begin
        fl_d = '0;
        if (s2_vld_q) begin
            case (sel)
                SEL_NAN:  fl_d[FLAG_INVALID] = inf_zero;
                SEL_OVF:  begin
                    fl_d[FLAG_OVERFLOW] = 1'b1;
                    fl_d[FLAG_INEXACT]  = 1'b1;
                end
                SEL_UNF:  begin
                    fl_d[FLAG_UNDERFLOW] = 1'b1;
                    fl_d[FLAG_INEXACT]   = |s2_q.prod;
                end
                SEL_NORM: fl_d[FLAG_INEXACT] = r_inexact;
                default:  fl_d = '0;
            endcase
        end
    end

    myreg #(.W(FLAGS_W)) u_out_fl (.clk(clk), .rst(rst), .en(advance), .d_i(fl_d), .q_o(bus.flags));
`endif
endmodule
